muldiv_seq: RTL and testbench

Multi-cycle multiply/divide sequencer for the EX stage. It accepts MULT/MULTU/DIV/DIVU ops from the ALU decode, runs a radix-2 restoring divider, and optionally runs a two-stage multiplier. It generates the EX stall and presents a 64-bit {HI,LO} result with a valid strobe to the HILO write path. It replaces the ad-hoc div handshake glue in the ALU, and it honours pipeline flush and downstream stall.

---
 rtl/muldiv_seq_pkg.sv | 28 ++
 rtl/muldiv_seq_div_radix2.sv | 59 +++++
 rtl/muldiv_seq.sv | 137 +++++++++++++
 tb/tb_muldiv_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: op codes, sequencer state encodings and shared helpers
// for the EX-stage multiply/divide sequencer.
package muldiv_seq_pkg;

  // ALU op codes (EXE_*_OP encoding) that the sequencer reacts to
  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  // one quotient bit per cycle
  localparam int MD_DIV_ITER = 32;

  typedef enum logic [2:0] {
    MD_IDLE     = 3'd0,
    MD_DIV_RUN  = 3'd1,
    MD_DIV_DONE = 3'd2,
    MD_MUL_WAIT = 3'd3,
    MD_HOLD     = 3'd4
  } md_state_e;

  // absolute value when the op is signed, pass-through otherwise
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_div_radix2.sv
// div_radix2: unsigned radix-2 restoring divider, 32 iterations after start.
// A start pulse reloads the operands and restarts the iteration at any time,
// so an abandoned division never needs an explicit abort.
module div_radix2
  import muldiv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [31:0] dvs, quo, rem;
  logic [4:0]  cnt;
  logic        run;
  logic [32:0] trial, diff;

  // shift the next dividend bit into the partial remainder and try a subtract
  assign trial = {rem, quo[31]};
  assign diff  = trial - {1'b0, dvs};

  // iteration state; a zero divisor never borrows, giving all-ones quotient
  // and the dividend as remainder
  always_ff @(posedge clk) begin
    if (!rst) begin
      dvs  <= '0;
      quo  <= '0;
      rem  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      dvs  <= divisor;
      quo  <= dividend;
      rem  <= '0;
      cnt  <= '0;
      run  <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      rem  <= diff[32] ? trial[31:0] : diff[31:0];
      quo  <= {quo[30:0], ~diff[32]};
      cnt  <= cnt + 5'd1;
      if (cnt == 5'(MD_DIV_ITER - 1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: EX-stage MULT/MULTU/DIV/DIVU sequencer. Generates the EX stall
// and a {HI,LO} result with a valid strobe for the HILO write path.
// Build option MULT_PIPE_EN registers the multiplier (2-cycle MULT);
// without it MULT is a single-cycle combinational product with no stall.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  op_e,
  input  logic [31:0] num1_e,
  input  logic [31:0] num2_e,
  input  logic        flush_e,
  input  logic        stall_m,
  output logic        stall_e,
  output logic        res_valid_e,
  output logic [63:0] res_e,
  output logic        busy
);

  md_state_e   state;
  logic [4:0]  cnt;
  logic        neg_q, neg_r;
  logic [63:0] res_q;
  logic        is_div, is_mul, sgn_op, launch_div;
  logic [31:0] quo, rem, q_fix, r_fix;
  logic        div_done;
  logic [63:0] prod;

  assign is_div = (op_e == EXE_DIV_OP) || (op_e == EXE_DIVU_OP);
  assign is_mul = (op_e == EXE_MULT_OP) || (op_e == EXE_MULTU_OP);
  assign sgn_op = (op_e == EXE_DIV_OP) || (op_e == EXE_MULT_OP);

  // the divider samples its magnitudes in the launch cycle itself
  assign launch_div = rst && !flush_e && (state == MD_IDLE) && is_div;

  // one 64x64 multiplier serves both signed and unsigned by operand extension
  assign prod = {{32{sgn_op & num1_e[31]}}, num1_e} *
                {{32{sgn_op & num2_e[31]}}, num2_e};

  // quotient negative when signs differ, remainder follows the dividend
  assign q_fix = neg_q ? (~quo + 32'd1) : quo;
  assign r_fix = neg_r ? (~rem + 32'd1) : rem;

  div_radix2 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (launch_div),
    .dividend  (mag(num1_e, sgn_op)),
    .divisor   (mag(num2_e, sgn_op)),
    .quotient  (quo),
    .remainder (rem),
    .done      (div_done)
  );

  // sequencer FSM: reset beats flush, flush beats the downstream stall
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res_q <= '0;
    end else if (flush_e) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (is_div) begin
            state <= MD_DIV_RUN;
            cnt   <= '0;
            neg_q <= (op_e == EXE_DIV_OP) && (num1_e[31] ^ num2_e[31]);
            neg_r <= (op_e == EXE_DIV_OP) && num1_e[31];
          end
`ifdef MULT_PIPE_EN
          else if (is_mul) begin
            state <= MD_MUL_WAIT;
            res_q <= prod;
          end
`endif
        end
        MD_DIV_RUN: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'(MD_DIV_ITER - 1)) state <= MD_DIV_DONE;
        end
        MD_DIV_DONE: begin
          // keep the fixed-up result for HOLD
          res_q <= {r_fix, q_fix};
          state <= stall_m ? MD_HOLD : MD_IDLE;
        end
`ifdef MULT_PIPE_EN
        MD_MUL_WAIT: state <= stall_m ? MD_HOLD : MD_IDLE;
`endif
        MD_HOLD: if (!stall_m) state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  // outputs decode from state; flush and reset kill them in the same cycle
  always_comb begin
    stall_e     = 1'b0;
    res_valid_e = 1'b0;
    res_e       = res_q;
    busy        = 1'b0;
    if (!rst) begin
      res_e = '0;
    end else if (!flush_e) begin
      busy = (state != MD_IDLE);
      case (state)
        MD_IDLE: begin
`ifdef MULT_PIPE_EN
          stall_e = is_div | is_mul;
`else
          stall_e = is_div;
          if (is_mul) begin
            res_valid_e = 1'b1;
            res_e       = prod;
          end
`endif
        end
        MD_DIV_RUN:  stall_e = 1'b1;
        MD_DIV_DONE: begin
          res_valid_e = div_done;
          res_e       = {r_fix, q_fix};
        end
`ifdef MULT_PIPE_EN
        MD_MUL_WAIT: res_valid_e = 1'b1;
`endif
        MD_HOLD:     res_valid_e = 1'b1;
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed bench for muldiv_seq (build with or without
// MULT_PIPE_EN). Inputs change 1 time unit after the rising edge, outputs are
// sampled on the falling edge; cycle 1 is the cycle an op is first presented.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush_e, stall_m;
  logic [7:0]  op_e;
  logic [31:0] num1_e, num2_e;
  logic        stall_e, res_valid_e, busy;
  logic [63:0] res_e;

  int errors = 0;
  int checks = 0;

`ifdef MULT_PIPE_EN
  localparam int MUL_STALLS = 1;
  localparam int MUL_VCYC   = 2;
`else
  localparam int MUL_STALLS = 0;
  localparam int MUL_VCYC   = 1;
`endif

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk         (clk),
    .rst         (rst),
    .op_e        (op_e),
    .num1_e      (num1_e),
    .num2_e      (num2_e),
    .flush_e     (flush_e),
    .stall_m     (stall_m),
    .stall_e     (stall_e),
    .res_valid_e (res_valid_e),
    .res_e       (res_e),
    .busy        (busy)
  );

  // present an op from the current cycle until its result strobe; operands
  // are scrambled after the launch cycle. Returns at the start of the cycle
  // after the strobe with op_e back to NOP.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int stalls,
                        output int vcyc, output logic [63:0] r);
    stalls = 0; vcyc = 0; r = '0;
    op_e = op; num1_e = a; num2_e = b;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (stall_e) stalls++;
      if (res_valid_e) begin vcyc = k; r = res_e; end
      @(posedge clk); #1;
      num1_e = $urandom; num2_e = $urandom;
      if (vcyc != 0) break;
    end
    op_e = EXE_NOP_OP;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush_e = 1'b0; stall_m = 1'b0;
    op_e = EXE_DIV_OP; num1_e = 32'd100; num2_e = 32'd7;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++; if (stall_e !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall_e); end
    checks++; if (res_valid_e !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", res_valid_e); end
    checks++; if (res_e !== 64'h0) begin errors++; $display("FAIL rst_res got=%h exp=0", res_e); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    rst = 1'b1; op_e = 8'h20;   // unrelated ALU op: no action
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++; if ({busy, stall_e, res_valid_e} !== 3'b000) begin errors++; $display("FAIL other_op got=%b exp=000", {busy, stall_e, res_valid_e}); end
    @(posedge clk); #1;
    op_e = EXE_NOP_OP;
  endtask

  task automatic test_divu();
    int s, v; logic [63:0] r;
    run_op(EXE_DIVU_OP, 32'd100, 32'd7, s, v, r);
    checks++; if (s !== 33) begin errors++; $display("FAIL divu_stalls got=%0d exp=33", s); end
    checks++; if (v !== 34) begin errors++; $display("FAIL divu_latency got=%0d exp=34", v); end
    checks++; if (r !== 64'h00000002_0000000E) begin errors++; $display("FAIL divu_res got=%h exp=%h", r, 64'h00000002_0000000E); end
    @(negedge clk);
    checks++; if ({res_valid_e, busy} !== 2'b00) begin errors++; $display("FAIL divu_pulse got=%b exp=00", {res_valid_e, busy}); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_signed();
    int s, v; logic [63:0] r;
    run_op(EXE_DIV_OP, 32'hFFFFFFF9, 32'h2, s, v, r);
    checks++; if (r !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_m7_2 got=%h exp=%h", r, 64'hFFFFFFFF_FFFFFFFD); end
    run_op(EXE_DIV_OP, 32'h7, 32'hFFFFFFFE, s, v, r);
    checks++; if (r !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL div_7_m2 got=%h exp=%h", r, 64'h00000001_FFFFFFFD); end
    run_op(EXE_DIV_OP, 32'hFFFFFFF9, 32'hFFFFFFFE, s, v, r);
    checks++; if (r !== 64'hFFFFFFFF_00000003) begin errors++; $display("FAIL div_m7_m2 got=%h exp=%h", r, 64'hFFFFFFFF_00000003); end
    run_op(EXE_DIVU_OP, 32'd5, 32'd0, s, v, r);
    checks++; if (r !== 64'h00000005_FFFFFFFF) begin errors++; $display("FAIL divu_by0 got=%h exp=%h", r, 64'h00000005_FFFFFFFF); end
    checks++; if (v !== 34) begin errors++; $display("FAIL divu_by0_lat got=%0d exp=34", v); end
    run_op(EXE_DIV_OP, 32'hFFFFFFF9, 32'd0, s, v, r);
    checks++; if (r !== 64'hFFFFFFF9_00000001) begin errors++; $display("FAIL div_by0_sgn got=%h exp=%h", r, 64'hFFFFFFF9_00000001); end
  endtask

  task automatic test_mult();
    int s, v; logic [63:0] r;
    run_op(EXE_MULT_OP, 32'hFFFFFFFF, 32'h2, s, v, r);
    checks++; if (r !== 64'hFFFFFFFF_FFFFFFFE) begin errors++; $display("FAIL mult_res got=%h exp=%h", r, 64'hFFFFFFFF_FFFFFFFE); end
    checks++; if (v !== MUL_VCYC) begin errors++; $display("FAIL mult_latency got=%0d exp=%0d", v, MUL_VCYC); end
    checks++; if (s !== MUL_STALLS) begin errors++; $display("FAIL mult_stalls got=%0d exp=%0d", s, MUL_STALLS); end
    run_op(EXE_MULTU_OP, 32'hFFFFFFFF, 32'h2, s, v, r);
    checks++; if (r !== 64'h00000001_FFFFFFFE) begin errors++; $display("FAIL multu_res got=%h exp=%h", r, 64'h00000001_FFFFFFFE); end
    checks++; if (v !== MUL_VCYC) begin errors++; $display("FAIL multu_latency got=%0d exp=%0d", v, MUL_VCYC); end
    run_op(EXE_MULT_OP, 32'h00012345, 32'h00010000, s, v, r);
    checks++; if (r !== 64'h00000001_23450000) begin errors++; $display("FAIL mult_pos got=%h exp=%h", r, 64'h00000001_23450000); end
  endtask

  // stall_m high in cycles 34..36 (DIV_DONE and two HOLD cycles); op stays DIVU
  task automatic test_hold();
    int vcnt = 0, bad = 0, relaunch = 0, first = 0, idle_bad = 0;
    op_e = EXE_DIVU_OP; num1_e = 32'd100; num2_e = 32'd7;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (res_valid_e) begin
        vcnt++;
        if (first == 0) first = k;
        if (res_e !== 64'h00000002_0000000E) bad++;
      end
      if (k >= 34 && k <= 37 && (stall_e || !busy)) relaunch++;
      if (k >= 38 && busy) idle_bad++;
      @(posedge clk); #1;
      stall_m = (k + 1 >= 34) && (k + 1 <= 36);
      if (k + 1 == 38) op_e = EXE_NOP_OP;
    end
    stall_m = 1'b0;
    checks++; if (first !== 34) begin errors++; $display("FAIL hold_first got=%0d exp=34", first); end
    checks++; if (vcnt !== 4) begin errors++; $display("FAIL hold_len got=%0d exp=4", vcnt); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_value got=%0d bad exp=0", bad); end
    checks++; if (relaunch !== 0) begin errors++; $display("FAIL hold_relaunch got=%0d exp=0", relaunch); end
    checks++; if (idle_bad !== 0) begin errors++; $display("FAIL hold_release got=%0d exp=0", idle_bad); end
  endtask

  // flush in DIV_RUN cycle 10 (cycle 12)
  task automatic test_flush();
    int s, v, vseen = 0, bseen = 0; logic [63:0] r;
    op_e = EXE_DIVU_OP; num1_e = 32'd100; num2_e = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++; if ({stall_e, busy} !== 2'b11) begin errors++; $display("FAIL flush_pre got=%b exp=11", {stall_e, busy}); end
    @(posedge clk); #1;
    flush_e = 1'b1; op_e = EXE_NOP_OP;
    @(negedge clk);
    checks++; if ({stall_e, busy, res_valid_e} !== 3'b000) begin errors++; $display("FAIL flush_same got=%b exp=000", {stall_e, busy, res_valid_e}); end
    @(posedge clk); #1;
    flush_e = 1'b0;
    @(negedge clk);
    checks++; if ({stall_e, busy} !== 2'b00) begin errors++; $display("FAIL flush_next got=%b exp=00", {stall_e, busy}); end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (res_valid_e) vseen++;
      if (busy) bseen++;
    end
    checks++; if (vseen + bseen !== 0) begin errors++; $display("FAIL flush_quiet got=%0d exp=0", vseen + bseen); end
    @(posedge clk); #1;
    run_op(EXE_DIV_OP, 32'hFFFFFFF9, 32'h2, s, v, r);
    checks++; if (r !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL flush_redo got=%h exp=%h", r, 64'hFFFFFFFF_FFFFFFFD); end
    checks++; if (v !== 34) begin errors++; $display("FAIL flush_redo_lat got=%0d exp=34", v); end
  endtask

  // reset in DIV_RUN cycle 20 (cycle 22)
  task automatic test_reset_mid();
    int vseen = 0;
    op_e = EXE_DIVU_OP; num1_e = 32'd100; num2_e = 32'd7;
    repeat (21) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; op_e = EXE_NOP_OP;
    @(negedge clk);
    checks++; if ({stall_e, res_valid_e, busy} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got=%b exp=000", {stall_e, res_valid_e, busy}); end
    checks++; if (res_e !== 64'h0) begin errors++; $display("FAIL rstmid_res got=%h exp=0", res_e); end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (res_valid_e || busy) vseen++;
    end
    checks++; if (vseen !== 0) begin errors++; $display("FAIL rstmid_discard got=%0d exp=0", vseen); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int s1, v1, s2, v2; logic [63:0] r1, r2;
    run_op(EXE_DIVU_OP, 32'd1000, 32'd10, s1, v1, r1);
    run_op(EXE_DIV_OP, 32'hFFFFFF9C, 32'd7, s2, v2, r2);   // -100 / 7
    checks++; if (r1 !== 64'h00000000_00000064) begin errors++; $display("FAIL b2b_res1 got=%h exp=%h", r1, 64'h00000000_00000064); end
    checks++; if (r2 !== 64'hFFFFFFFE_FFFFFFF2) begin errors++; $display("FAIL b2b_res2 got=%h exp=%h", r2, 64'hFFFFFFFE_FFFFFFF2); end
    checks++; if (s2 !== 33) begin errors++; $display("FAIL b2b_stalls got=%0d exp=33", s2); end
    checks++; if (v2 !== 34) begin errors++; $display("FAIL b2b_latency got=%0d exp=34", v2); end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_mult();
    test_hold();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
